// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the gcd_feeder sequencer and its operand FIFO.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } gcd_feed_state_t;

    localparam int GCD_WIDTH       = 4;
    localparam int GCD_DEPTH       = 4;
    localparam int GCD_CALC_CYCLES = 20;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of {x,y} operand pairs; extra pointer MSB distinguishes full from empty.
module gcd_pair_fifo
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int DEPTH = GCD_DEPTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               push,
    input  logic [2*WIDTH-1:0] wdata,
    input  logic               pop,
    output logic [2*WIDTH-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [2*WIDTH-1:0]   mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/gcd_feeder.sv
// Feeds buffered operand pairs to gcd_module with a fixed go window and
// returns each result (or a zero-operand error) over a valid/ready handshake.
module gcd_feeder
    import gcd_pkg::*;
#(
    parameter int WIDTH       = GCD_WIDTH,
    parameter int DEPTH       = GCD_DEPTH,
    parameter int CALC_CYCLES = GCD_CALC_CYCLES
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             go,
    output logic [WIDTH-1:0] xin,
    output logic [WIDTH-1:0] yin,
    input  logic [WIDTH-1:0] gcd,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_gcd,
    output logic             res_err,
    output logic             busy
);

    localparam int CW = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CALC_CYCLES - 1);

    gcd_feed_state_t state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] xin_n, yin_n, res_gcd_n;
    logic             res_err_n;
    logic             push, pop, full, empty;
    logic [2*WIDTH-1:0] head;
    logic [WIDTH-1:0] head_x, head_y;

    assign push   = in_valid && !full;
    assign head_x = head[2*WIDTH-1:WIDTH];
    assign head_y = head[WIDTH-1:0];

    gcd_pair_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .wdata ({in_x, in_y}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state   <= IDLE;
            cnt     <= '0;
            xin     <= '0;
            yin     <= '0;
            res_gcd <= '0;
            res_err <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            xin     <= xin_n;
            yin     <= yin_n;
            res_gcd <= res_gcd_n;
            res_err <= res_err_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        xin_n     = xin;
        yin_n     = yin;
        res_gcd_n = res_gcd;
        res_err_n = res_err;
        pop       = 1'b0;
        go        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop   = 1'b1;
                    xin_n = head_x;
                    yin_n = head_y;
                    // A zero operand would never converge in gcd_module, so skip the computation.
                    if (head_x == '0 || head_y == '0) begin
                        res_gcd_n = '0;
                        res_err_n = 1'b1;
                        state_n   = DONE;
                    end else begin
                        state_n = LOAD;
                    end
                end
            end
            LOAD: begin
                cnt_n   = '0;
                state_n = RUN;
            end
            RUN: begin
                go = 1'b1;
                if (cnt == CNT_LAST) begin
                    res_gcd_n = gcd;
                    res_err_n = 1'b0;
                    cnt_n     = '0;
                    state_n   = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign in_ready  = !full;
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE) || !empty;

endmodule

// File: tb/tb_gcd_feeder.sv
// Self-checking bench for gcd_feeder: behavioural gcd_module, software-GCD scoreboard,
// directed timing scenarios and a randomized backpressure run.
module tb_gcd_feeder;

    localparam int W    = 4;
    localparam int CALC = 20;

    typedef struct {
        logic [W-1:0] g;
        logic         err;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr;
    logic         in_valid, in_ready;
    logic [W-1:0] in_x, in_y;
    logic         go;
    logic [W-1:0] xin, yin, gcd;
    logic         res_valid, res_ready;
    logic [W-1:0] res_gcd;
    logic         res_err, busy;

    int vectors     = 0;
    int miscompares = 0;
    exp_t exp_q[$];

    gcd_feeder #(.WIDTH(W), .DEPTH(4), .CALC_CYCLES(CALC)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .go        (go),
        .xin       (xin),
        .yin       (yin),
        .gcd       (gcd),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_gcd   (res_gcd),
        .res_err   (res_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural gcd_module: reload while go is low, one subtractive Euclid step per cycle while high.
    logic [W-1:0] mx, my;
    always_ff @(posedge clk) begin
        if (!go) begin
            mx <= xin;
            my <= yin;
        end else if (mx > my) begin
            mx <= mx - my;
        end else if (my > mx) begin
            my <= my - mx;
        end
    end
    assign gcd = mx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        int p, q, t;
        if (a == 0 || b == 0) begin
            r.g   = '0;
            r.err = 1'b1;
        end else begin
            p = a;
            q = b;
            while (q != 0) begin
                t = p % q;
                p = q;
                q = t;
            end
            r.g   = W'(p);
            r.err = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard and go-window monitor, sampled mid-cycle.
    int           run_len = 0;
    logic [W-1:0] held_x, held_y;
    always @(negedge clk) begin
        if (clr) begin
            run_len = 0;
        end else begin
            if (in_valid && in_ready) exp_q.push_back(model(in_x, in_y));
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_gcd", res_gcd, e.g);
                    check("res_err", res_err, e.err);
                end
            end
            if (go) begin
                check("go_no_result", res_valid, 0);
                if (run_len == 0) begin
                    held_x = xin;
                    held_y = yin;
                    check("go_nonzero_ops", (xin != 0 && yin != 0), 1);
                end else begin
                    check("xin_stable", xin, held_x);
                    check("yin_stable", yin, held_y);
                end
                run_len++;
            end else if (run_len != 0) begin
                check("go_len", run_len, CALC);
                run_len = 0;
            end
        end
    end

    // Called at posedge+1; returns at accept-edge+1.
    task automatic push(input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok = 0;
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
        in_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !res_valid) ok = 1;
        end
        check("idle_timeout", ok, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rv;
        int go_cnt;
        bit drv_done;
        clr = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_go", go, 0);
        check("rst_xin", xin, 0);
        check("rst_yin", yin, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_gcd", res_gcd, 0);
        check("rst_res_err", res_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Single job timing: (15,3)
        res_ready = 1'b1;
        push(4'd15, 4'd3);
        first_rv = 0;
        go_cnt   = 0;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                check("t1_go_edge1", go, 0);
                check("t1_xin", xin, 15);
                check("t1_yin", yin, 3);
            end
            if (e == 2) check("t1_go_edge2", go, 1);
            if (go) go_cnt++;
            if (res_valid && first_rv == 0) first_rv = e;
        end
        check("t1_go_cycles", go_cnt, CALC);
        check("t1_res_valid_edge", first_rv, 22);
        wait_idle();

        // Back-to-back jobs
        push(4'd12, 4'd8);
        push(4'd9, 4'd6);
        push(4'd7, 4'd5);
        wait_idle();

        // Zero operand, then a normal job
        push(4'd0, 4'd5);
        @(posedge clk);
        #1;
        check("zero_res_valid", res_valid, 1);
        check("zero_res_err", res_err, 1);
        check("zero_res_gcd", res_gcd, 0);
        check("zero_go", go, 0);
        push(4'd6, 4'd4);
        wait_idle();

        // Backpressure: six pairs with res_ready low
        res_ready = 1'b0;
        push(4'd14, 4'd4);
        push(4'd15, 4'd10);
        push(4'd8, 4'd12);
        push(4'd13, 4'd0);
        push(4'd9, 4'd15);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_busy", busy, 1);
        fork
            push(4'd10, 4'd6);
            begin
                repeat (30) @(posedge clk);
                #2;
                check("bp_still_full", in_ready, 0);
                check("bp_res_valid_held", res_valid, 1);
                res_ready = 1'b1;
            end
        join
        wait_idle();

        // Clear mid-RUN with pairs queued
        push(4'd15, 4'd1);
        push(4'd14, 4'd7);
        push(4'd9, 4'd3);
        repeat (5) @(posedge clk);
        #1;
        check("clr_pre_go", go, 1);
        clr = 1'b1;
        exp_q.delete();
        #1;
        check("clr_go", go, 0);
        check("clr_res_valid", res_valid, 0);
        check("clr_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("clr_no_stale_busy", busy, 0);
        check("clr_no_stale_valid", res_valid, 0);
        push(4'd10, 4'd4);
        wait_idle();

        // Randomized traffic with random downstream backpressure
        drv_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [W-1:0] a, b;
                    a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
                    b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 15));
                    push(a, b);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drv_done = 1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #2;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
